// File: rtl/pwm_pkg.sv
// Shared PWM constants and types, used by both the PWM generator and the duty meter.
package pwm_pkg;

    localparam int unsigned DEF_CNT_W       = 24;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_TIMEOUT_CYC = 5_000_000;
    localparam int unsigned DUTY_W          = 8;
    localparam int unsigned PCT_SCALE       = 100;
    // Extra numerator bits needed to hold high_time * PCT_SCALE
    localparam int unsigned PCT_EXT_W       = 7;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_e;

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Measurement bus of the PWM duty meter: PWM input in, period/high/duty results out.
interface pwm_duty_meter_if
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic              PWM_In;
    logic [CNT_W-1:0]  Period_Out;
    logic [CNT_W-1:0]  High_Out;
    logic [DUTY_W-1:0] Duty_Out;
    logic              Valid;
    logic              Timeout;

    modport master (
        output PWM_In,
        input  Period_Out, High_Out, Duty_Out, Valid, Timeout
    );

    modport slave (
        input  PWM_In,
        output Period_Out, High_Out, Duty_Out, Valid, Timeout
    );

endinterface

// File: rtl/pwm_duty_divider.sv
// Restoring divider for the duty percentage: one quotient bit per cycle, 8 bits total.
// Busy is held until the result has been latched by the consumer, giving a 10-cycle turnaround.
module pwm_duty_divider
    import pwm_pkg::*;
#(
    parameter int unsigned DEN_W = DEF_CNT_W,
    parameter int unsigned NUM_W = DEF_CNT_W + PCT_EXT_W
) (
    input  logic              CLK,
    input  logic              Rstn,
    input  logic              i_start,
    input  logic [NUM_W-1:0]  i_num,
    input  logic [DEN_W-1:0]  i_den,
    output logic              o_busy,
    output logic              o_done,
    output logic [DUTY_W-1:0] o_quot
);

    localparam int unsigned     STEP_W    = 4;
    localparam logic [STEP_W-1:0] LAST_ITER = STEP_W'(7);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(9);

    logic [DEN_W-1:0]  r_rem;
    logic [DEN_W-1:0]  r_den;
    logic [DUTY_W-1:0] r_num;
    logic [DUTY_W-1:0] r_q;
    logic [STEP_W-1:0] r_step;
    logic              r_den_zero;

    logic              w_load;
    logic [DEN_W-1:0]  w_den;
    logic [DEN_W-1:0]  w_rem;
    logic              w_bit;
    logic [DEN_W:0]    w_trial;
    logic              w_ge;
    logic [DEN_W-1:0]  w_rem_nx;
    logic [DUTY_W-1:0] w_q_base;
    logic [DUTY_W-1:0] w_q_nx;

    assign w_load = i_start && (r_step == '0);

    // One restoring step; the load cycle already consumes the top quotient bit.
    always_comb begin
        w_den    = r_den;
        w_rem    = r_rem;
        w_bit    = r_num[DUTY_W-1];
        w_q_base = r_q;
        if (w_load) begin
            w_den    = i_den;
            w_rem    = DEN_W'(i_num[NUM_W-1:DUTY_W]);
            w_bit    = i_num[DUTY_W-1];
            w_q_base = '0;
        end
        w_trial  = {w_rem, w_bit};
        w_ge     = (w_trial >= {1'b0, w_den});
        w_rem_nx = w_ge ? DEN_W'(w_trial - {1'b0, w_den}) : w_trial[DEN_W-1:0];
        w_q_nx   = {w_q_base[DUTY_W-2:0], w_ge};
    end

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            r_rem      <= '0;
            r_den      <= '0;
            r_num      <= '0;
            r_q        <= '0;
            r_step     <= '0;
            r_den_zero <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_quot     <= '0;
        end else begin
            o_done <= 1'b0;
            if (w_load) begin
                r_rem      <= w_rem_nx;
                r_num      <= {i_num[DUTY_W-2:0], 1'b0};
                r_den      <= i_den;
                r_den_zero <= (i_den == '0);
                r_q        <= w_q_nx;
                r_step     <= STEP_W'(1);
                o_busy     <= 1'b1;
            end else if (r_step != '0) begin
                if (r_step <= LAST_ITER) begin
                    r_rem <= w_rem_nx;
                    r_num <= {r_num[DUTY_W-2:0], 1'b0};
                    r_q   <= w_q_nx;
                end
                if (r_step == LAST_ITER) begin
                    o_quot <= r_den_zero ? '0 : w_q_nx;
                    o_done <= 1'b1;
                end
                if (r_step == LAST_STEP) begin
                    r_step <= '0;
                    o_busy <= 1'b0;
                end else begin
                    r_step <= r_step + STEP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: synchronises PWM_In, measures period/high time and reports the duty percentage.
// Optional macro PWM_GLITCH_FILT_EN inserts a 3-sample stability filter ahead of the edge detector.
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int unsigned      CNT_W       = DEF_CNT_W,
    parameter int unsigned      SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(DEF_TIMEOUT_CYC)
) (
    input  logic             CLK,
    input  logic             Rstn,
    pwm_duty_meter_if.slave  bus
);

    localparam int unsigned      NUM_W   = CNT_W + PCT_EXT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi_cap;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high;
    logic [DUTY_W-1:0]      r_duty;
    logic                   r_valid;
    logic                   r_timeout;
    meas_state_e            r_state;

    logic                   w_lvl;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_start;
    logic                   w_tmo_hit;
    logic [NUM_W-1:0]       w_num;
    logic                   w_busy;
    logic                   w_done;
    logic [DUTY_W-1:0]      w_quot;

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], bus.PWM_In};
    end

`ifdef PWM_GLITCH_FILT_EN
    logic       r_filt_lvl;
    logic [1:0] r_stab_cnt;

    // Level follows the synchroniser only after 3 consecutive differing samples.
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            r_filt_lvl <= 1'b0;
            r_stab_cnt <= '0;
        end else if (r_sync[SYNC_STAGES-1] == r_filt_lvl) begin
            r_stab_cnt <= '0;
        end else if (r_stab_cnt == 2'd2) begin
            r_filt_lvl <= r_sync[SYNC_STAGES-1];
            r_stab_cnt <= '0;
        end else begin
            r_stab_cnt <= r_stab_cnt + 2'd1;
        end
    end

    assign w_lvl = r_filt_lvl;
`else
    assign w_lvl = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) r_prev <= 1'b0;
        else       r_prev <= w_lvl;
    end

    assign w_rise = w_lvl & ~r_prev;
    assign w_fall = ~w_lvl & r_prev;

    // Cycle counter restarts at 1 on each rise so it reads the period at the next rise.
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn)               r_cnt <= '0;
        else if (w_rise)         r_cnt <= CNT_W'(1);
        else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_start   = (r_state == ST_MEASURE) && w_rise && !r_timeout && !w_busy;
    assign w_num     = NUM_W'(r_hi_cap) * NUM_W'(PCT_SCALE);
    assign w_tmo_hit = (r_cnt == TIMEOUT_CYC) && !r_timeout && !w_rise;

    pwm_duty_divider #(
        .DEN_W (CNT_W),
        .NUM_W (NUM_W)
    ) u_div (
        .CLK     (CLK),
        .Rstn    (Rstn),
        .i_start (w_start),
        .i_num   (w_num),
        .i_den   (r_cnt),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_quot  (w_quot)
    );

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            r_state   <= ST_IDLE;
            r_hi_cap  <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_duty    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_done) begin
                r_duty  <= w_quot;
                r_valid <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state   <= ST_MEASURE;
                        r_timeout <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (w_fall) r_hi_cap <= r_cnt;
                    // A rise after a timeout only restarts the measurement.
                    if (w_rise) begin
                        if (r_timeout) begin
                            r_timeout <= 1'b0;
                        end else begin
                            r_period <= r_cnt;
                            r_high   <= r_hi_cap;
                        end
                    end
                end
            endcase
            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
                r_duty    <= w_lvl ? DUTY_W'(PCT_SCALE) : '0;
                r_valid   <= 1'b1;
            end
        end
    end

    assign bus.Period_Out = r_period;
    assign bus.High_Out   = r_high;
    assign bus.Duty_Out   = r_duty;
    assign bus.Valid      = r_valid;
    assign bus.Timeout    = r_timeout;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: vector table of periodic waveforms plus timeout/reset/glitch sequences.
module tb_pwm_duty_meter;

    localparam int unsigned      CW  = 24;
    localparam logic [CW-1:0]    TMO = 24'd1200;
`ifdef PWM_GLITCH_FILT_EN
    localparam int FILT_LAT = 3;
`else
    localparam int FILT_LAT = 0;
`endif

    logic CLK  = 1'b0;
    logic Rstn = 1'b0;
    always #5 CLK = ~CLK;

    pwm_duty_meter_if #(.CNT_W(CW)) bus ();

    pwm_duty_meter #(
        .CNT_W       (CW),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .CLK  (CLK),
        .Rstn (Rstn),
        .bus  (bus)
    );

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;

    always @(posedge CLK) if (bus.Valid === 1'b1) valid_cnt <= valid_cnt + 1;

    typedef struct {
        string name;
        int    per;
        int    hi;
        int    nper;
        int    e_period;
        int    e_high;
        int    e_duty;
        int    e_valid;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.PWM_In = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset(input logic lvl);
        Rstn       = 1'b0;
        bus.PWM_In = lvl;
        repeat (3) @(negedge CLK);
        Rstn = 1'b1;
    endtask

    task automatic wait_valid(input int maxc, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < maxc && !ok) begin
            @(negedge CLK);
            cyc++;
            if (bus.Valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic chk_outs(input string nm, input int p, input int h, input int d, input int tmo);
        chk({nm, ".period"},  32'(bus.Period_Out), p);
        chk({nm, ".high"},    32'(bus.High_Out),   h);
        chk({nm, ".duty"},    32'(bus.Duty_Out),   d);
        chk({nm, ".timeout"}, 32'(bus.Timeout),    tmo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int  v0, cyc;
        bit  ok;

        vecs[0] = '{"p1000_h250", 1000, 250, 3, 1000, 250, 25, 3};
`ifdef PWM_GLITCH_FILT_EN
        vecs[1] = '{"p7_h3",      7,    3,   4, 7,    3,   42, 2};
        vecs[5] = '{"p200_h197",  200,  197, 2, 200,  197, 98, 2};
`else
        vecs[1] = '{"p7_h2",      7,    2,   4, 7,    2,   28, 2};
        vecs[5] = '{"p200_h199",  200,  199, 2, 200,  199, 99, 2};
`endif
        vecs[2] = '{"p10_h3",     10,   3,   4, 10,   3,   30, 4};
        vecs[3] = '{"p9_h3",      9,    3,   4, 9,    3,   33, 2};
        vecs[4] = '{"p400_h100",  400,  100, 3, 400,  100, 25, 3};
        vecs[6] = '{"p100_h50",   100,  50,  2, 100,  50,  50, 2};

        // Reset state
        bus.PWM_In = 1'b0;
        do_reset(1'b0);
        @(negedge CLK);
        chk_outs("reset", 0, 0, 0, 0);
        chk("reset.valid", 32'(bus.Valid), 0);

        // Periodic waveforms from the table
        for (int i = 0; i < 7; i++) begin
            do_reset(1'b0);
            v0 = valid_cnt;
            drive(1'b0, 5);
            for (int p = 0; p < vecs[i].nper; p++) begin
                drive(1'b1, vecs[i].hi);
                drive(1'b0, vecs[i].per - vecs[i].hi);
            end
            drive(1'b1, 20);
            chk_outs(vecs[i].name, vecs[i].e_period, vecs[i].e_high, vecs[i].e_duty, 0);
            chk({vecs[i].name, ".valids"}, 32'(valid_cnt - v0), vecs[i].e_valid);
        end

        // Input held high: timeout with 100 %, then a 50/100 waveform recovers
        do_reset(1'b1);
        wait_valid(1500, cyc, ok);
        chk("hi_tmo.seen", 32'(ok), 1);
        chk("hi_tmo.cycle", 32'(cyc), 32'(1203 + FILT_LAT));
        chk_outs("hi_tmo", 0, 0, 100, 1);
        repeat (2) @(negedge CLK);
        v0 = valid_cnt;
        drive(1'b1, 100);
        chk("hi_tmo.single_valid", 32'(valid_cnt - v0), 0);
        chk("hi_tmo.held", 32'(bus.Timeout), 1);
        drive(1'b0, 50);
        drive(1'b1, 8);
        chk("hi_tmo.cleared", 32'(bus.Timeout), 0);
        chk("hi_tmo.no_result_on_restart", 32'(valid_cnt - v0), 0);
        drive(1'b1, 42);
        drive(1'b0, 50);
        drive(1'b1, 20);
        chk_outs("recover", 100, 50, 50, 0);
        chk("recover.valids", 32'(valid_cnt - v0), 1);

        // Input held low: timeout with 0 %
        do_reset(1'b0);
        wait_valid(1500, cyc, ok);
        chk("lo_tmo.seen", 32'(ok), 1);
        chk("lo_tmo.cycle", 32'(cyc), 1201);
        chk_outs("lo_tmo", 0, 0, 0, 1);

        // Reset asserted while a divide is in flight
        do_reset(1'b0);
        drive(1'b0, 5);
        drive(1'b1, 100);
        drive(1'b0, 300);
        drive(1'b1, 5);
        chk("pre_rst.period", 32'(bus.Period_Out), 400);
        Rstn = 1'b0;
        #1;
        chk_outs("mid_rst", 0, 0, 0, 0);
        chk("mid_rst.valid", 32'(bus.Valid), 0);
        repeat (2) @(negedge CLK);
        Rstn = 1'b1;
        v0 = valid_cnt;
        drive(1'b1, 10);
        drive(1'b0, 300);
        chk("post_rst.no_valid_first_rise", 32'(valid_cnt - v0), 0);
        drive(1'b1, 100);
        drive(1'b0, 300);
        drive(1'b1, 20);
        chk_outs("post_rst", 400, 100, 25, 0);
        chk("post_rst.valids", 32'(valid_cnt - v0), 2);

        // 2-cycle low glitch inside a 200-cycle high phase
        do_reset(1'b0);
        v0 = valid_cnt;
        drive(1'b0, 5);
        drive(1'b1, 100);
        drive(1'b0, 2);
        drive(1'b1, 98);
        drive(1'b0, 200);
        drive(1'b1, 20);
`ifdef PWM_GLITCH_FILT_EN
        chk_outs("glitch", 400, 200, 50, 0);
        chk("glitch.valids", 32'(valid_cnt - v0), 1);
`else
        chk_outs("glitch", 298, 98, 32, 0);
        chk("glitch.valids", 32'(valid_cnt - v0), 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
